ym_timer_ctrl: RTL and testbench

- Control and prescaler stage directly upstream of the two ym_timer instances (Timer A 10-bit, Timer B 8-bit) in the YM2610 audio model.
- Decodes CPU writes to registers 0x24-0x27 into per-timer load value, load, run and flag-clear strobes.
- Generates the TICK_A and TICK_B timebases.
- Folds the timers' overflow flags back into the status bits and the nIRQ line.

---
 rtl/ym_timer_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ym_timer_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ym_timer_ctrl.sv
// Register decode, free-running prescaler and IRQ folding for the YM2610 Timer A/B pair.
// Bus writes take effect one cycle after WR; STATUS/nIRQ follow the overflow flags by one cycle.
module ym_timer_ctrl #(
   parameter int PRESCALE = 144,
   parameter int B_DIV    = 16
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       WR,
   input  logic       A0,
   input  logic [7:0] DIN,
   output logic       TICK_A,
   output logic       TICK_B,
   output logic [9:0] TA_VALUE,
   output logic [7:0] TB_VALUE,
   output logic       LOAD_A,
   output logic       LOAD_B,
   output logic       CLR_RUN_A,
   output logic       CLR_RUN_B,
   output logic       CLR_FLAG_A,
   output logic       CLR_FLAG_B,
   input  logic       OVF_FLAG_A,
   input  logic       OVF_FLAG_B,
   output logic [1:0] STATUS,
   output logic       nIRQ
);

   localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int DIV_W = (B_DIV > 1) ? $clog2(B_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(B_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             tick_a_q, tick_a_d;
   logic             tick_b_q, tick_b_d;
   logic [7:0]       addr_q, addr_d;
   logic [9:0]       ta_q, ta_d;
   logic [7:0]       tb_q, tb_d;
   logic             start_a_q, start_a_d;
   logic             start_b_q, start_b_d;
   logic             en_a_q, en_a_d;
   logic             en_b_q, en_b_d;
   logic             pend_a_q, pend_a_d;
   logic             pend_b_q, pend_b_d;
   logic             clr_run_a_q, clr_run_a_d;
   logic             clr_run_b_q, clr_run_b_d;
   logic             clr_flag_a_q, clr_flag_a_d;
   logic             clr_flag_b_q, clr_flag_b_d;
   logic [1:0]       status_q, status_d;
   logic             nirq_q, nirq_d;
   logic             wrap;

   always_comb begin
      wrap         = (cnt_q == CNT_LAST);
      cnt_d        = wrap ? '0 : cnt_q + 1'b1;
      div_d        = div_q;
      if (wrap) begin
         div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      end
      tick_a_d     = wrap;
      tick_b_d     = wrap && (div_q == DIV_LAST);

      addr_d       = addr_q;
      ta_d         = ta_q;
      tb_d         = tb_q;
      start_a_d    = start_a_q;
      start_b_d    = start_b_q;
      en_a_d       = en_a_q;
      en_b_d       = en_b_q;
      // A pending load survives until the timer has had one tick to sample it.
      pend_a_d     = pend_a_q & ~tick_a_q;
      pend_b_d     = pend_b_q & ~tick_b_q;
      clr_run_a_d  = 1'b0;
      clr_run_b_d  = 1'b0;
      clr_flag_a_d = 1'b0;
      clr_flag_b_d = 1'b0;

      status_d     = {OVF_FLAG_B & en_b_q, OVF_FLAG_A & en_a_q};
      nirq_d       = ~|status_d;

      if (WR && !A0) begin
         addr_d = DIN;
      end else if (WR && A0) begin
         case (addr_q)
            8'h24: ta_d[9:2] = DIN;
            8'h25: ta_d[1:0] = DIN[1:0];
            8'h26: tb_d      = DIN;
            8'h27: begin
               if (DIN[0] && !start_a_q) pend_a_d = 1'b1;
               if (!DIN[0]) begin
                  pend_a_d    = 1'b0;
                  clr_run_a_d = 1'b1;
               end
               if (DIN[1] && !start_b_q) pend_b_d = 1'b1;
               if (!DIN[1]) begin
                  pend_b_d    = 1'b0;
                  clr_run_b_d = 1'b1;
               end
               start_a_d    = DIN[0];
               start_b_d    = DIN[1];
               en_a_d       = DIN[2];
               en_b_d       = DIN[3];
               clr_flag_a_d = DIN[4];
               clr_flag_b_d = DIN[5];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cnt_q        <= '0;
         div_q        <= '0;
         tick_a_q     <= 1'b0;
         tick_b_q     <= 1'b0;
         addr_q       <= '0;
         ta_q         <= '0;
         tb_q         <= '0;
         start_a_q    <= 1'b0;
         start_b_q    <= 1'b0;
         en_a_q       <= 1'b0;
         en_b_q       <= 1'b0;
         pend_a_q     <= 1'b0;
         pend_b_q     <= 1'b0;
         clr_run_a_q  <= 1'b0;
         clr_run_b_q  <= 1'b0;
         clr_flag_a_q <= 1'b0;
         clr_flag_b_q <= 1'b0;
         status_q     <= '0;
         nirq_q       <= 1'b1;
      end else begin
         cnt_q        <= cnt_d;
         div_q        <= div_d;
         tick_a_q     <= tick_a_d;
         tick_b_q     <= tick_b_d;
         addr_q       <= addr_d;
         ta_q         <= ta_d;
         tb_q         <= tb_d;
         start_a_q    <= start_a_d;
         start_b_q    <= start_b_d;
         en_a_q       <= en_a_d;
         en_b_q       <= en_b_d;
         pend_a_q     <= pend_a_d;
         pend_b_q     <= pend_b_d;
         clr_run_a_q  <= clr_run_a_d;
         clr_run_b_q  <= clr_run_b_d;
         clr_flag_a_q <= clr_flag_a_d;
         clr_flag_b_q <= clr_flag_b_d;
         status_q     <= status_d;
         nirq_q       <= nirq_d;
      end
   end

   assign TICK_A     = tick_a_q;
   assign TICK_B     = tick_b_q;
   assign TA_VALUE   = ta_q;
   assign TB_VALUE   = tb_q;
   assign LOAD_A     = pend_a_q;
   assign LOAD_B     = pend_b_q;
   assign CLR_RUN_A  = clr_run_a_q;
   assign CLR_RUN_B  = clr_run_b_q;
   assign CLR_FLAG_A = clr_flag_a_q;
   assign CLR_FLAG_B = clr_flag_b_q;
   assign STATUS     = status_q;
   assign nIRQ       = nirq_q;

endmodule

// File: tb/tb_ym_timer_ctrl.sv
// Bench for ym_timer_ctrl: directed scenarios plus random bus traffic against a behavioural model.
// Prescaler expectations come from edge counts since reset release.
module tb_ym_timer_ctrl;

   localparam int PRESCALE = 144;
   localparam int B_DIV    = 16;

   logic       CLK, RESET, WR, A0;
   logic [7:0] DIN;
   logic       TICK_A, TICK_B;
   logic [9:0] TA_VALUE;
   logic [7:0] TB_VALUE;
   logic       LOAD_A, LOAD_B, CLR_RUN_A, CLR_RUN_B, CLR_FLAG_A, CLR_FLAG_B;
   logic       OVF_FLAG_A, OVF_FLAG_B;
   logic [1:0] STATUS;
   logic       nIRQ;

   ym_timer_ctrl #(.PRESCALE(PRESCALE), .B_DIV(B_DIV)) dut (
      .CLK(CLK), .RESET(RESET), .WR(WR), .A0(A0), .DIN(DIN),
      .TICK_A(TICK_A), .TICK_B(TICK_B), .TA_VALUE(TA_VALUE), .TB_VALUE(TB_VALUE),
      .LOAD_A(LOAD_A), .LOAD_B(LOAD_B), .CLR_RUN_A(CLR_RUN_A), .CLR_RUN_B(CLR_RUN_B),
      .CLR_FLAG_A(CLR_FLAG_A), .CLR_FLAG_B(CLR_FLAG_B),
      .OVF_FLAG_A(OVF_FLAG_A), .OVF_FLAG_B(OVF_FLAG_B),
      .STATUS(STATUS), .nIRQ(nIRQ)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_total = 0;
   int n_bad   = 0;

   // Reference model state
   int         edges;
   logic [7:0] m_addr, m_tb;
   logic [9:0] m_ta;
   logic       m_sa, m_sb, m_ea, m_eb, m_pa, m_pb;
   logic       m_tick_a, m_tick_b, m_cra, m_crb, m_cfa, m_cfb, m_nirq;
   logic [1:0] m_status;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      edges = 0;
      m_addr = 0; m_ta = 0; m_tb = 0;
      m_sa = 0; m_sb = 0; m_ea = 0; m_eb = 0; m_pa = 0; m_pb = 0;
      m_tick_a = 0; m_tick_b = 0; m_cra = 0; m_crb = 0; m_cfa = 0; m_cfb = 0;
      m_status = 0; m_nirq = 1;
   endtask

   task automatic model_step();
      logic old_ta = m_tick_a;
      logic old_tb = m_tick_b;
      logic [7:0] d = DIN;
      edges++;
      m_tick_a = (edges % PRESCALE) == 0;
      m_tick_b = (edges % (PRESCALE * B_DIV)) == 0;
      m_status = {OVF_FLAG_B & m_eb, OVF_FLAG_A & m_ea};
      m_nirq   = (m_status == 2'b00);
      m_cra = 0; m_crb = 0; m_cfa = 0; m_cfb = 0;
      if (m_pa && old_ta) m_pa = 0;
      if (m_pb && old_tb) m_pb = 0;
      if (WR && !A0) m_addr = d;
      else if (WR && A0) begin
         if (m_addr == 8'h24) m_ta[9:2] = d;
         else if (m_addr == 8'h25) m_ta[1:0] = d[1:0];
         else if (m_addr == 8'h26) m_tb = d;
         else if (m_addr == 8'h27) begin
            if (d[0] && !m_sa) m_pa = 1;
            if (!d[0]) begin m_pa = 0; m_cra = 1; end
            if (d[1] && !m_sb) m_pb = 1;
            if (!d[1]) begin m_pb = 0; m_crb = 1; end
            m_sa = d[0]; m_sb = d[1]; m_ea = d[2]; m_eb = d[3];
            m_cfa = d[4]; m_cfb = d[5];
         end
      end
   endtask

   task automatic check_all();
      chk("tick_a", TICK_A, m_tick_a);
      chk("tick_b", TICK_B, m_tick_b);
      chk("ta_value", TA_VALUE, m_ta);
      chk("tb_value", TB_VALUE, m_tb);
      chk("load_a", LOAD_A, m_pa);
      chk("load_b", LOAD_B, m_pb);
      chk("clr_run_a", CLR_RUN_A, m_cra);
      chk("clr_run_b", CLR_RUN_B, m_crb);
      chk("clr_flag_a", CLR_FLAG_A, m_cfa);
      chk("clr_flag_b", CLR_FLAG_B, m_cfb);
      chk("status", STATUS, m_status);
      chk("nirq", nIRQ, m_nirq);
   endtask

   // One clock: model follows the edge, outputs compared on the falling edge.
   task automatic cycle();
      @(posedge CLK);
      model_step();
      @(negedge CLK);
      check_all();
   endtask

   task automatic bus(input logic a, input logic [7:0] d);
      WR = 1; A0 = a; DIN = d;
      cycle();
      WR = 0;
   endtask

   initial begin
      int guard;
      RESET = 1; WR = 0; A0 = 0; DIN = 0; OVF_FLAG_A = 0; OVF_FLAG_B = 0;
      model_reset();
      repeat (3) @(negedge CLK);
      check_all();
      RESET = 0;

      // Load values
      bus(0, 8'h24); bus(1, 8'hAB); bus(0, 8'h25); bus(1, 8'hFE);
      chk("ta_direct", TA_VALUE, 10'h2AE);
      bus(0, 8'h26); bus(1, 8'h5C);
      chk("tb_direct", TB_VALUE, 8'h5C);

      // Deferred load held until a tick has passed, then no reload on rewrite
      bus(0, 8'h27); bus(1, 8'h01);
      chk("load_a_rise", LOAD_A, 1);
      guard = 0;
      while (m_pa && guard < 300) begin cycle(); guard++; end
      chk("load_a_bounded", guard < 300, 1);
      bus(1, 8'h01);
      chk("no_reload", LOAD_A, 0);

      // Stop cancels a pending B load
      bus(1, 8'h02);
      chk("load_b_pend", LOAD_B, 1);
      bus(1, 8'h00);
      chk("clr_run_b_pulse", CLR_RUN_B, 1);
      chk("load_b_drop", LOAD_B, 0);
      cycle();
      chk("clr_run_b_once", CLR_RUN_B, 0);

      // IRQ masking
      OVF_FLAG_A = 1;
      repeat (3) cycle();
      chk("masked_status", STATUS, 2'b00);
      chk("masked_nirq", nIRQ, 1);
      bus(1, 8'h04);
      cycle();
      chk("unmask_status", STATUS, 2'b01);
      chk("unmask_nirq", nIRQ, 0);
      bus(1, 8'h14);
      chk("clr_flag_a_pulse", CLR_FLAG_A, 1);
      cycle();
      chk("clr_flag_a_once", CLR_FLAG_A, 0);

      // Random traffic, long enough to cross the first TICK_B
      for (int i = 0; i < 3000; i++) begin
         int r = $urandom_range(0, 15);
         if ($urandom_range(0, 31) == 0) OVF_FLAG_A = ~OVF_FLAG_A;
         if ($urandom_range(0, 31) == 0) OVF_FLAG_B = ~OVF_FLAG_B;
         if (r == 0) begin
            int s = $urandom_range(0, 4);
            WR = 1; A0 = 0;
            DIN = (s == 4) ? 8'($urandom) : 8'(8'h24 + s);
         end else if (r <= 2) begin
            WR = 1; A0 = 1; DIN = 8'($urandom);
         end else begin
            WR = 0;
         end
         cycle();
      end
      WR = 0;

      // Asynchronous reset while a load is pending
      OVF_FLAG_A = 1;
      bus(0, 8'h24); bus(1, 8'hFF);
      bus(0, 8'h27); bus(1, 8'h04); bus(1, 8'h05);
      cycle(); cycle();
      #2 RESET = 1;
      #1;
      chk("arst_load_a", LOAD_A, 0);
      chk("arst_tick_a", TICK_A, 0);
      chk("arst_ta_value", TA_VALUE, 0);
      chk("arst_nirq", nIRQ, 1);
      chk("arst_status", STATUS, 0);
      @(negedge CLK);
      model_reset();
      OVF_FLAG_A = 0;
      RESET = 0;
      repeat (400) cycle();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
